// File: rtl/rice_pkg.sv
// Shared definitions for the Rice encoder datapath: widths, escape code,
// scheduler state encoding and the signed-to-unsigned fold.
package rice_pkg;

    localparam int unsigned SAMPLE_W    = 16;
    localparam int unsigned PARAM_W     = 4;
    localparam int unsigned RICE_ESCAPE = 15;

    typedef enum logic [1:0] {
        StFill   = 2'd0,
        StChoose = 2'd1,
        StDrain  = 2'd2
    } sched_state_e;

    // Zig-zag fold: s >= 0 -> 2s, s < 0 -> -2s-1.
    function automatic logic [SAMPLE_W-1:0] fold(input logic signed [SAMPLE_W-1:0] s);
        return {s[SAMPLE_W-2:0], 1'b0} ^ {SAMPLE_W{s[SAMPLE_W-1]}};
    endfunction

endpackage

// File: rtl/rice_partition_scheduler_if.sv
// Sample-in / sample-out bus of the partition scheduler.
// Optional override inputs exist only when RICE_PARAM_OVERRIDE_EN is defined.
interface rice_partition_scheduler_if;
    import rice_pkg::*;

    logic                       iValid;
    logic signed [SAMPLE_W-1:0] iSample;
    logic                       oReady;
    logic signed [SAMPLE_W-1:0] oSample;
    logic [PARAM_W-1:0]         oRiceParam;
    logic                       oValid;
    logic                       oParamValid;
    logic                       oPartDone;
`ifdef RICE_PARAM_OVERRIDE_EN
    logic                       iOverrideEn;
    logic [PARAM_W-1:0]         iOverrideParam;

    modport slave (
        input  iValid, iSample, iOverrideEn, iOverrideParam,
        output oReady, oSample, oRiceParam, oValid, oParamValid, oPartDone
    );
    modport master (
        output iValid, iSample, iOverrideEn, iOverrideParam,
        input  oReady, oSample, oRiceParam, oValid, oParamValid, oPartDone
    );
`else
    modport slave (
        input  iValid, iSample,
        output oReady, oSample, oRiceParam, oValid, oParamValid, oPartDone
    );
    modport master (
        output iValid, iSample,
        input  oReady, oSample, oRiceParam, oValid, oParamValid, oPartDone
    );
`endif

endinterface

// File: rtl/rice_param_search.sv
// Accumulates folded magnitudes of a partition and steps the Rice parameter
// candidate k until PART_SIZE<<k covers the sum or k reaches MAX_PARAM.
module rice_param_search
    import rice_pkg::*;
#(
    parameter int unsigned PART_SIZE = 16,
    parameter int unsigned LOG2_PART = 4,
    parameter int unsigned MAX_PARAM = 14
) (
    input  logic                iClock,
    input  logic                iReset,
    input  logic                i_clear,
    input  logic                i_accum,
    input  logic [SAMPLE_W-1:0] i_fold,
    input  logic                i_step,
    output logic [PARAM_W-1:0]  o_k,
    output logic                o_done
);

    localparam int unsigned SUM_W = LOG2_PART + 17;

    logic [SUM_W-1:0]   r_sum;
    logic [PARAM_W-1:0] r_k;
    logic [SUM_W-1:0]   w_thresh;

    // Candidate acceptance for the current k.
    always_comb begin
        w_thresh = SUM_W'(PART_SIZE) << r_k;
        o_done   = (w_thresh >= r_sum) || (r_k == PARAM_W'(MAX_PARAM));
        o_k      = r_k;
    end

    // Sum accumulation during fill, k stepping during the search.
    always_ff @(posedge iClock) begin
        if (iReset || i_clear) begin
            r_sum <= '0;
            r_k   <= '0;
        end else begin
            if (i_accum) begin
                r_sum <= r_sum + SUM_W'(i_fold);
            end
            if (i_step && !o_done) begin
                r_k <= r_k + PARAM_W'(1);
            end
        end
    end

endmodule

// File: rtl/rice_partition_scheduler.sv
// Buffers one partition of residuals, picks its Rice parameter and replays
// the samples one per cycle. Optional macro: RICE_PARAM_OVERRIDE_EN adds an
// external parameter override applied on the first CHOOSE cycle.
module rice_partition_scheduler
    import rice_pkg::*;
#(
    parameter int unsigned PART_SIZE = 16,
    parameter int unsigned LOG2_PART = 4,
    parameter int unsigned MAX_PARAM = 14
) (
    input  logic                     iClock,
    input  logic                     iReset,
    rice_partition_scheduler_if.slave bus
);

    sched_state_e               r_state;
    sched_state_e               w_state_next;
    logic [LOG2_PART-1:0]       r_count;
    logic signed [SAMPLE_W-1:0] r_buf [PART_SIZE];
    logic signed [SAMPLE_W-1:0] r_sample;
    logic [PARAM_W-1:0]         r_param;
    logic                       r_valid;
    logic                       r_param_valid;
    logic                       r_part_done;

    logic                       w_accept;
    logic                       w_last_in;
    logic                       w_drain_end;
    logic [PARAM_W-1:0]         w_k;
    logic                       w_done;
    logic                       w_choose_done;
    logic [PARAM_W-1:0]         w_param_sel;

    assign w_accept    = bus.iValid && (r_state == StFill);
    assign w_last_in   = w_accept && (r_count == LOG2_PART'(PART_SIZE - 1));
    // r_part_done marks the cycle showing the last sample; leave DRAIN after it.
    assign w_drain_end = (r_state == StDrain) && r_part_done;

`ifdef RICE_PARAM_OVERRIDE_EN
    logic w_override;
    assign w_override    = bus.iOverrideEn && (w_k == '0);
    assign w_choose_done = w_done || w_override;
    assign w_param_sel   = !w_override ? w_k :
                           (bus.iOverrideParam > PARAM_W'(MAX_PARAM)) ? PARAM_W'(MAX_PARAM) :
                           bus.iOverrideParam;
`else
    assign w_choose_done = w_done;
    assign w_param_sel   = w_k;
`endif

    rice_param_search #(
        .PART_SIZE (PART_SIZE),
        .LOG2_PART (LOG2_PART),
        .MAX_PARAM (MAX_PARAM)
    ) u_search (
        .iClock  (iClock),
        .iReset  (iReset),
        .i_clear (w_drain_end),
        .i_accum (w_accept),
        .i_fold  (fold(bus.iSample)),
        .i_step  (r_state == StChoose),
        .o_k     (w_k),
        .o_done  (w_done)
    );

    // State register.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_state <= StFill;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StFill:   if (w_last_in)     w_state_next = StChoose;
            StChoose: if (w_choose_done) w_state_next = StDrain;
            StDrain:  if (r_part_done)   w_state_next = StFill;
            default:                     w_state_next = StFill;
        endcase
    end

    // Partition buffer write; contents need no reset.
    always_ff @(posedge iClock) begin
        if (w_accept) begin
            r_buf[r_count] <= bus.iSample;
        end
    end

    // Index counter, parameter latch and registered replay outputs.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_count       <= '0;
            r_sample      <= '0;
            r_param       <= '0;
            r_valid       <= 1'b0;
            r_param_valid <= 1'b0;
            r_part_done   <= 1'b0;
        end else begin
            r_valid       <= 1'b0;
            r_param_valid <= 1'b0;
            r_part_done   <= 1'b0;
            unique case (r_state)
                StFill: begin
                    if (w_accept) begin
                        r_count <= r_count + LOG2_PART'(1);
                    end
                end
                StChoose: begin
                    if (w_choose_done) begin
                        r_param <= w_param_sel;
                    end
                end
                StDrain: begin
                    // Counter wraps to 0 on the last read, ready for the next fill.
                    if (!r_part_done) begin
                        r_sample      <= r_buf[r_count];
                        r_valid       <= 1'b1;
                        r_param_valid <= (r_count == '0);
                        r_part_done   <= (r_count == LOG2_PART'(PART_SIZE - 1));
                        r_count       <= r_count + LOG2_PART'(1);
                    end
                end
                default: r_count <= '0;
            endcase
        end
    end

    assign bus.oReady      = (r_state == StFill);
    assign bus.oSample     = r_sample;
    assign bus.oRiceParam  = r_param;
    assign bus.oValid      = r_valid;
    assign bus.oParamValid = r_param_valid;
    assign bus.oPartDone   = r_part_done;

endmodule

// File: tb/tb_rice_partition_scheduler.sv
// Randomised self-checking bench for rice_partition_scheduler (PART_SIZE=16).
module tb_rice_partition_scheduler;

    localparam int PS   = 16;
    localparam int MAXK = 14;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    logic signed [15:0] part [PS];

    rice_partition_scheduler_if bus ();

    rice_partition_scheduler #(
        .PART_SIZE (16),
        .LOG2_PART (4),
        .MAX_PARAM (14)
    ) dut (
        .iClock (clk),
        .iReset (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint ref_fold(input int s);
        return (s >= 0) ? longint'(2 * s) : longint'(-2 * s - 1);
    endfunction

    // Smallest k with PS * 2^k >= sum, capped at MAXK.
    function automatic int ref_k(input longint sum);
        int k = 0;
        while (k < MAXK && (longint'(PS) * (longint'(1) << k)) < sum) k++;
        return k;
    endfunction

    function automatic int rand_sample();
        int w;
        int v;
        w = $urandom_range(0, 15);
        v = int'($urandom & ((32'd1 << w) - 1));
        return ($urandom_range(0, 1) == 1) ? -v : v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feed part[] then check parameter, latency and replay. forced_k >= 0 means override.
    task automatic run_partition(input string name, input bit hold, input int forced_k);
        longint sum = 0;
        int     k_exp;
        int     lat_exp;
        int     lat = 0;
        bit     seen = 0;
        bit     bad_idle = 0;
        for (int i = 0; i < PS; i++) sum += ref_fold(int'(part[i]));
        k_exp   = (forced_k >= 0) ? forced_k : ref_k(sum);
        lat_exp = (forced_k >= 0) ? 2 : k_exp + 2;

        n_checks++;
        if (bus.oReady !== 1'b1) $display("FAIL %s ready_before_fill got=%b want=1", name, bus.oReady);
        else n_pass++;

        for (int i = 0; i < PS; i++) begin
            bus.iValid  = 1'b1;
            bus.iSample = part[i];
            tick();
        end
        if (!hold) bus.iValid = 1'b0;

        for (int n = 1; n <= 40 && !seen; n++) begin
            if (hold) bus.iSample = 16'($urandom);
            tick();
            if (bus.oValid === 1'b1) begin
                seen = 1;
                lat  = n;
            end else if (bus.oReady !== 1'b0) begin
                bad_idle = 1;
            end
        end
        n_checks++;
        if (!seen || lat != lat_exp)
            $display("FAIL %s latency got=%0d want=%0d", name, lat, lat_exp);
        else n_pass++;
        n_checks++;
        if (bad_idle) $display("FAIL %s ready_in_choose got=1 want=0", name);
        else n_pass++;
        if (!seen) return;

        n_checks++;
        if (bus.oRiceParam !== 4'(k_exp) || bus.oParamValid !== 1'b1 || bus.oSample !== part[0])
            $display("FAIL %s first_out got=k%0d pv%b s%0d want=k%0d pv1 s%0d", name,
                     bus.oRiceParam, bus.oParamValid, bus.oSample, k_exp, part[0]);
        else n_pass++;

        for (int i = 1; i < PS; i++) begin
            if (hold) bus.iSample = 16'($urandom);
            tick();
            n_checks++;
            if (bus.oValid !== 1'b1 || bus.oSample !== part[i] || bus.oParamValid !== 1'b0 ||
                bus.oRiceParam !== 4'(k_exp) || bus.oPartDone !== (i == PS - 1) ||
                bus.oReady !== 1'b0)
                $display("FAIL %s out[%0d] got=v%b s%0d k%0d pv%b pd%b r%b want=v1 s%0d k%0d pv0 pd%b r0",
                         name, i, bus.oValid, bus.oSample, bus.oRiceParam, bus.oParamValid,
                         bus.oPartDone, bus.oReady, part[i], k_exp, i == PS - 1);
            else n_pass++;
        end

        if (hold) bus.iSample = 16'($urandom);
        tick();
        n_checks++;
        if (bus.oValid !== 1'b0 || bus.oReady !== 1'b1 || bus.oPartDone !== 1'b0 ||
            bus.oRiceParam !== 4'(k_exp))
            $display("FAIL %s after_drain got=v%b r%b pd%b k%0d want=v0 r1 pd0 k%0d", name,
                     bus.oValid, bus.oReady, bus.oPartDone, bus.oRiceParam, k_exp);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        bus.iValid  = 1'b1;
        bus.iSample = 16'sd100;
        repeat (3) tick();
        n_checks++;
        if (bus.oReady !== 1'b1 || bus.oValid !== 1'b0 || bus.oSample !== 16'sd0 ||
            bus.oRiceParam !== 4'd0 || bus.oParamValid !== 1'b0 || bus.oPartDone !== 1'b0)
            $display("FAIL reset_state got=r%b v%b s%0d k%0d pv%b pd%b want=r1 v0 s0 k0 pv0 pd0",
                     bus.oReady, bus.oValid, bus.oSample, bus.oRiceParam, bus.oParamValid,
                     bus.oPartDone);
        else n_pass++;
        bus.iValid = 1'b0;
        rst        = 1'b0;
        tick();
    endtask

    task automatic test_constants();
        for (int i = 0; i < PS; i++) part[i] = 16'sd0;
        run_partition("zeros", 0, -1);
        for (int i = 0; i < PS; i++) part[i] = 16'sd8;
        run_partition("plus8", 0, -1);
        for (int i = 0; i < PS; i++) part[i] = -16'sd1;
        run_partition("minus1", 0, -1);
        for (int i = 0; i < PS; i++) part[i] = 16'sh7FFF;
        run_partition("max_cap", 0, -1);
        for (int i = 0; i < PS; i++) part[i] = 16'sh8000;
        run_partition("min_cap", 0, -1);
    endtask

    task automatic test_random();
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < PS; i++) part[i] = 16'(rand_sample());
            run_partition("random", 0, -1);
            repeat ($urandom_range(0, 3)) tick();
        end
    endtask

    task automatic test_back_to_back();
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < PS; i++) part[i] = 16'(rand_sample());
            run_partition("back_to_back", 1, -1);
        end
        bus.iValid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_drain();
        bit seen = 0;
        bit leak = 0;
        for (int i = 0; i < PS; i++) part[i] = 16'(rand_sample());
        for (int i = 0; i < PS; i++) begin
            bus.iValid  = 1'b1;
            bus.iSample = part[i];
            tick();
        end
        bus.iValid = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            tick();
            if (bus.oValid === 1'b1) seen = 1;
        end
        n_checks++;
        if (!seen) $display("FAIL mid_reset no_drain got=0 want=1");
        else n_pass++;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (bus.oValid !== 1'b0 || bus.oPartDone !== 1'b0 || bus.oReady !== 1'b1)
            $display("FAIL mid_reset got=v%b pd%b r%b want=v0 pd0 r1",
                     bus.oValid, bus.oPartDone, bus.oReady);
        else n_pass++;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (bus.oValid !== 1'b0 || bus.oPartDone !== 1'b0) leak = 1;
        end
        n_checks++;
        if (leak) $display("FAIL mid_reset_leak got=1 want=0");
        else n_pass++;
        for (int i = 0; i < PS; i++) part[i] = 16'(rand_sample());
        run_partition("after_reset", 0, -1);
    endtask

`ifdef RICE_PARAM_OVERRIDE_EN
    task automatic test_override();
        for (int i = 0; i < PS; i++) part[i] = 16'sd0;
        bus.iOverrideEn    = 1'b1;
        bus.iOverrideParam = 4'd7;
        run_partition("override7", 0, 7);
        for (int i = 0; i < PS; i++) part[i] = 16'sh7FFF;
        bus.iOverrideParam = 4'd15;
        run_partition("override_sat", 0, MAXK);
        bus.iOverrideEn = 1'b0;
    endtask
`endif

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        rst         = 1'b1;
        bus.iValid  = 1'b0;
        bus.iSample = '0;
`ifdef RICE_PARAM_OVERRIDE_EN
        bus.iOverrideEn    = 1'b0;
        bus.iOverrideParam = '0;
`endif
        test_reset();
        test_constants();
        test_random();
        test_back_to_back();
        test_reset_mid_drain();
`ifdef RICE_PARAM_OVERRIDE_EN
        test_override();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
